// File: rtl/gaussian_filter.sv
// Streaming 3x3 Gaussian blur over a raster-order grayscale frame.
// Two line buffers feed a 3x3 window; the filtered pixel is registered one cycle after window completion.
module gaussian_filter #(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       data_valid,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [7:0]    lb0_q [IMG_WIDTH];
  logic [7:0]    lb0_d [IMG_WIDTH];
  logic [7:0]    lb1_q [IMG_WIDTH];
  logic [7:0]    lb1_d [IMG_WIDTH];
  logic [7:0]    win_q [3][3];
  logic [7:0]    win_d [3][3];
  logic          win_valid_q, win_valid_d;
  logic          win_last_q, win_last_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          valid_out_q, valid_out_d;
  logic          done_q, done_d;
  logic          accept_s;
  logic          col_last_s;
  logic          row_last_s;
  logic [11:0]   sum_s;

  // Raster position of the pixel being accepted this cycle.
  always_comb begin
    accept_s   = enable & data_valid;
    col_last_s = (col_q == COL_LAST);
    row_last_s = (row_q == ROW_LAST);
    col_d      = col_q;
    row_d      = row_q;
    if (accept_s) begin
      if (col_last_s) begin
        col_d = {CW{1'b0}};
        if (row_last_s) begin
          row_d = {RW{1'b0}};
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
        row_d = row_q;
      end
    end else begin
      col_d = col_q;
      row_d = row_q;
    end
  end

  // Window shift and line-buffer rotation; lb1 holds row-2, lb0 holds row-1.
  always_comb begin
    win_d       = win_q;
    lb0_d       = lb0_q;
    lb1_d       = lb1_q;
    win_valid_d = 1'b0;
    win_last_d  = 1'b0;
    if (accept_s) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2]   = lb1_q[col_q];
      win_d[1][2]   = lb0_q[col_q];
      win_d[2][2]   = data_in;
      lb1_d[col_q]  = lb0_q[col_q];
      lb0_d[col_q]  = data_in;
      win_valid_d   = (row_q >= ROW_TWO) && (col_q >= COL_TWO);
      win_last_d    = col_last_s && row_last_s;
    end else begin
      win_valid_d = 1'b0;
      win_last_d  = 1'b0;
    end
  end

  // Kernel [1 2 1; 2 4 2; 1 2 1]; max 16*255 fits in 12 bits.
  always_comb begin
    sum_s = {4'd0, win_q[0][0]} + {3'd0, win_q[0][1], 1'b0} + {4'd0, win_q[0][2]}
          + {3'd0, win_q[1][0], 1'b0} + {2'd0, win_q[1][1], 2'b00} + {3'd0, win_q[1][2], 1'b0}
          + {4'd0, win_q[2][0]} + {3'd0, win_q[2][1], 1'b0} + {4'd0, win_q[2][2]};
    valid_out_d = win_valid_q;
    done_d      = win_valid_q & win_last_q;
    if (win_valid_q) begin
      data_out_d = sum_s[11:4];
    end else begin
      data_out_d = data_out_q;
    end
  end

  // Position, window and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= {CW{1'b0}};
      row_q       <= {RW{1'b0}};
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      data_out_q  <= 8'h00;
      valid_out_q <= 1'b0;
      done_q      <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= 8'h00;
        end
      end
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      done_q      <= done_d;
      win_q       <= win_d;
    end
  end

  // Line buffers carry no reset; rows 0-1 never produce output so stale contents are harmless.
  always_ff @(posedge clk) begin
    lb0_q <= lb0_d;
    lb1_q <= lb1_d;
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign done      = done_q;

endmodule

// File: tb/tb_gaussian_filter.sv
// Self-checking bench for gaussian_filter: a frame-level reference model predicts every output
// and its cycle; directed frames plus hand-computed constants pin the model.
module tb_gaussian_filter;

  localparam int W = 8;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       data_valid;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       done;

  gaussian_filter #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .data_valid (data_valid),
    .data_in    (data_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int d;
    int dn;
    int r;
    int c;
  } exp_t;

  exp_t expq[$];
  exp_t me;
  exp_t ce;
  int   img [H][W];
  int   cap [H][W];
  int   vals[$];
  int   mr = 0;
  int   mc = 0;
  int   edge_cnt = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   out_cnt = 0;
  int   done_cnt = 0;
  int   last_d = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Blur of the 3x3 neighbourhood whose bottom-right pixel is (r,c).
  function automatic int ref_pix(input int r, input int c);
    int s;
    s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += ((i == 1) ? 2 : 1) * ((j == 1) ? 2 : 1) * img[r - 2 + i][c - 2 + j];
    return s / 16;
  endfunction

  // Reference model: tracks accepted pixels and schedules each expected output for the following edge.
  always @(posedge clk) begin
    edge_cnt++;
    if (!rst_n) begin
      mr = 0;
      mc = 0;
      expq.delete();
    end else if (enable && data_valid) begin
      img[mr][mc] = data_in;
      if (mr >= 2 && mc >= 2) begin
        me.due = edge_cnt + 1;
        me.d   = ref_pix(mr, mc);
        me.dn  = (mr == H - 1 && mc == W - 1) ? 1 : 0;
        me.r   = mr - 1;
        me.c   = mc - 1;
        expq.push_back(me);
      end
      if (mc == W - 1) begin
        mc = 0;
        mr = (mr == H - 1) ? 0 : mr + 1;
      end else begin
        mc++;
      end
    end
  end

  // Compare DUT outputs against the model every cycle.
  always @(posedge clk) begin
    #1;
    if (!rst_n) last_d = 0;
    while (expq.size() > 0 && expq[0].due < edge_cnt) begin
      chk("missed_output", 0, 1);
      void'(expq.pop_front());
    end
    if (expq.size() > 0 && expq[0].due == edge_cnt) begin
      ce = expq.pop_front();
      chk("valid_out", int'(valid_out), 1);
      chk("data_out", int'(data_out), ce.d);
      chk("done", int'(done), ce.dn);
      cap[ce.r][ce.c] = int'(data_out);
      last_d = ce.d;
    end else begin
      chk("valid_idle", int'(valid_out), 0);
      chk("done_idle", int'(done), 0);
      chk("data_hold", int'(data_out), last_d);
    end
    if (valid_out) begin
      out_cnt++;
      vals.push_back(int'(data_out));
    end
    if (done) done_cnt++;
  end

  task automatic clear_counts();
    out_cnt  = 0;
    done_cnt = 0;
    vals.delete();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        cap[r][c] = -1;
  endtask

  task automatic px(input logic [7:0] p, input int gap);
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      enable     = 1'b1;
      data_valid = 1'b0;
      data_in    = 8'($urandom);
    end
    @(negedge clk);
    enable     = 1'b1;
    data_valid = 1'b1;
    data_in    = p;
  endtask

  task automatic end_frame();
    @(negedge clk);
    data_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("queue_drained", expq.size(), 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    enable     = 1'b1;
    data_valid = 1'b0;
    data_in    = 8'h00;
    clear_counts();
    repeat (2) @(negedge clk);
    chk("reset_data_out", int'(data_out), 0);
    chk("reset_valid_out", int'(valid_out), 0);
    chk("reset_done", int'(done), 0);
    rst_n = 1'b1;

    // Constant 100, valid held high.
    clear_counts();
    for (int i = 0; i < W * H; i++) px(8'd100, 0);
    end_frame();
    chk("c100_count", out_cnt, 36);
    chk("c100_done", done_cnt, 1);
    chk("c100_first", vals[0], 100);
    chk("c100_last", vals[35], 100);

    // Constant 255: full-scale sum 4080.
    clear_counts();
    for (int i = 0; i < W * H; i++) px(8'd255, 0);
    end_frame();
    chk("c255_count", out_cnt, 36);
    chk("c255_first", vals[0], 255);
    chk("c255_centre", cap[4][4], 255);

    // Impulse of 160 at (3,3).
    clear_counts();
    for (int i = 0; i < W * H; i++) px((i == 3 * W + 3) ? 8'd160 : 8'd0, 0);
    end_frame();
    chk("imp_count", out_cnt, 36);
    chk("imp_centre", cap[3][3], 40);
    chk("imp_up", cap[2][3], 20);
    chk("imp_left", cap[3][2], 20);
    chk("imp_right", cap[3][4], 20);
    chk("imp_down", cap[4][3], 20);
    chk("imp_diag_ul", cap[2][2], 10);
    chk("imp_diag_dr", cap[4][4], 10);
    chk("imp_far", cap[1][1], 0);
    chk("imp_far2", cap[6][6], 0);

    // Random pixels, valid gaps (forced at row ends), enable low 5 cycles mid-row.
    clear_counts();
    for (int i = 0; i < W * H; i++) begin
      px(8'($urandom_range(0, 255)), (i % W == 0) ? 3 : $urandom_range(0, 2));
      if (i == 3 * W + 3) begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          enable     = 1'b0;
          data_valid = 1'b1;
          data_in    = 8'($urandom);
        end
      end
    end
    end_frame();
    chk("rand_count", out_cnt, 36);
    chk("rand_done", done_cnt, 1);

    // Reset after 20 pixels, then a constant-50 frame.
    for (int i = 0; i < 20; i++) px(8'($urandom_range(0, 255)), 0);
    @(negedge clk);
    data_valid = 1'b0;
    rst_n      = 1'b0;
    @(negedge clk);
    chk("midreset_valid", int'(valid_out), 0);
    chk("midreset_data", int'(data_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_counts();
    for (int i = 0; i < W * H; i++) px(8'd50, 0);
    end_frame();
    chk("c50_count", out_cnt, 36);
    chk("c50_done", done_cnt, 1);
    chk("c50_first", vals[0], 50);
    chk("c50_last", vals[35], 50);

    // Back-to-back frames: all 10 then all 200.
    clear_counts();
    for (int i = 0; i < 2 * W * H; i++) px((i < W * H) ? 8'd10 : 8'd200, 0);
    end_frame();
    chk("b2b_count", out_cnt, 72);
    chk("b2b_done", done_cnt, 2);
    chk("b2b_f1_first", vals[0], 10);
    chk("b2b_f1_last", vals[35], 10);
    chk("b2b_f2_first", vals[36], 200);
    chk("b2b_f2_last", vals[71], 200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
